// File: rtl/mips_cpu_instr_memory_if.sv
// Program-load and instruction-fetch signals shared by the program source/CPU
// (master) and the instruction memory responder (slave).
interface mips_cpu_instr_memory_if;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic        load_ready;
   logic        load_done;
   logic        load_error;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;

   modport master (
      output load_valid,
      output load_byte,
      output load_last,
      output instr_address,
      input  load_ready,
      input  load_done,
      input  load_error,
      input  instr_readdata
   );

   modport slave (
      input  load_valid,
      input  load_byte,
      input  load_last,
      input  instr_address,
      output load_ready,
      output load_done,
      output load_error,
      output instr_readdata
   );
endinterface

// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for mips_cpu_harvard: byte-serial program load, then
// combinational word fetch from the reset vector upward.
module mips_cpu_instr_memory #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
   input logic                    clk,
   input logic                    reset,
   input logic                    clk_enable,
   mips_cpu_instr_memory_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(DEPTH_WORDS + 1);

   typedef enum logic {
      LOAD,
      DONE
   } state_t;

   state_t        state;
   logic          ready;
   logic          done;
   logic          error;
   logic [1:0]    lane;
   logic [31:0]   asm_word;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] word_count;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          write_due;
   logic          full;
   logic [4:0]    shift;
   logic [31:0]   merged;
   logic [29:0]   idx;
   logic          hit;

   assign accept    = bus.load_valid & ready & clk_enable;
   assign write_due = accept & (bus.load_last | (lane == 2'd3));
   assign full      = (word_count == CW'(DEPTH_WORDS));
   assign shift     = {2'd3 - lane, 3'b000};
   // Lanes not yet filled are still zero, so a last byte pads for free.
   assign merged    = asm_word | ({24'h0, bus.load_byte} << shift);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= LOAD;
         ready      <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         lane       <= 2'd0;
         asm_word   <= '0;
         wr_ptr     <= '0;
         word_count <= '0;
      end else if (clk_enable) begin
         if (accept) begin
            lane     <= bus.load_last ? 2'd0 : lane + 2'd1;
            asm_word <= write_due ? '0 : merged;
            if (write_due) begin
               if (full) begin
                  error <= 1'b1;
               end else begin
                  wr_ptr     <= wr_ptr + AW'(1);
                  word_count <= word_count + CW'(1);
               end
            end
            if (bus.load_last) begin
               state <= DONE;
               ready <= 1'b0;
               done  <= 1'b1;
            end
         end else if (state == LOAD) begin
            ready <= 1'b1;
         end
      end
   end

   // Array is never cleared; word_count hides stale contents.
   always_ff @(posedge clk) begin
      if (reset && write_due && !full) begin
         mem[wr_ptr] <= merged;
      end
   end

   assign idx = bus.instr_address[31:2] - BASE_ADDR[31:2];
   assign hit = done
              & (bus.instr_address[1:0] == 2'b00)
              & (bus.instr_address >= BASE_ADDR)
              & (idx < 30'(word_count));

   assign bus.instr_readdata = hit ? mem[idx[AW-1:0]] : 32'h0;
   assign bus.load_ready     = ready;
   assign bus.load_done      = done;
   assign bus.load_error     = error;
endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Bench for mips_cpu_instr_memory: two instances (deep and 2-word) share one
// load stream; fetch expectations flow through a scoreboard queue.
module tb_mips_cpu_instr_memory;
   localparam logic [31:0] BASE = 32'hBFC00000;
   localparam int DEPTH_A = 256;
   localparam int DEPTH_B = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic [31:0] instr_address;

   int n_checks = 0;
   int n_pass = 0;

   mips_cpu_instr_memory_if bus_a();
   mips_cpu_instr_memory_if bus_b();

   assign bus_a.load_valid    = load_valid;
   assign bus_a.load_byte     = load_byte;
   assign bus_a.load_last     = load_last;
   assign bus_a.instr_address = instr_address;
   assign bus_b.load_valid    = load_valid;
   assign bus_b.load_byte     = load_byte;
   assign bus_b.load_last     = load_last;
   assign bus_b.instr_address = instr_address;

   mips_cpu_instr_memory #(
      .DEPTH_WORDS(DEPTH_A),
      .BASE_ADDR  (BASE)
   ) dut_a (
      .clk       (clk),
      .reset     (reset),
      .clk_enable(clk_enable),
      .bus       (bus_a)
   );

   mips_cpu_instr_memory #(
      .DEPTH_WORDS(DEPTH_B),
      .BASE_ADDR  (BASE)
   ) dut_b (
      .clk       (clk),
      .reset     (reset),
      .clk_enable(clk_enable),
      .bus       (bus_b)
   );

   always #5 clk = ~clk;

   logic [7:0]  m_bytes[$];
   logic [31:0] m_words[$];
   bit          m_done;

   typedef struct {
      string       tag;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } exp_t;

   exp_t sb[$];

   logic [7:0] prog1[16] = '{
      8'h24, 8'h00, 8'h00, 8'h01, 8'h24, 8'h02, 8'h00, 8'h01,
      8'h00, 8'h00, 8'h00, 8'h08, 8'h24, 8'h00, 8'h00, 8'h00
   };

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic void model_reset();
      m_bytes.delete();
      m_words.delete();
      m_done = 1'b0;
   endfunction

   function automatic void model_finish();
      while (m_bytes.size() % 4 != 0) m_bytes.push_back(8'h00);
      for (int i = 0; i < m_bytes.size(); i += 4)
         m_words.push_back({m_bytes[i], m_bytes[i+1],
                            m_bytes[i+2], m_bytes[i+3]});
      m_done = 1'b1;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr,
                                              input int depth);
      int unsigned word_idx;
      int unsigned cnt;
      if (!m_done || addr[1:0] != 2'b00 || addr < BASE) return 32'h0;
      word_idx = (addr - BASE) >> 2;
      cnt = (m_words.size() < depth) ? m_words.size() : depth;
      if (word_idx < cnt) return m_words[word_idx];
      return 32'h0;
   endfunction

   function automatic logic model_error(input int depth);
      return m_done && (m_words.size() > depth);
   endfunction

   task automatic fetch(input string tag, input logic [31:0] addr);
      exp_t e;
      sb.push_back('{tag: tag,
                     exp_a: model_read(addr, DEPTH_A),
                     exp_b: model_read(addr, DEPTH_B)});
      instr_address = addr;
      #1;
      e = sb.pop_front();
      check({e.tag, "_a"}, bus_a.instr_readdata, e.exp_a);
      check({e.tag, "_b"}, bus_b.instr_readdata, e.exp_b);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_ready_a"}, 32'(bus_a.load_ready), 32'(!m_done));
      check({tag, "_ready_b"}, 32'(bus_b.load_ready), 32'(!m_done));
      check({tag, "_done_a"}, 32'(bus_a.load_done), 32'(m_done));
      check({tag, "_done_b"}, 32'(bus_b.load_done), 32'(m_done));
      check({tag, "_err_a"}, 32'(bus_a.load_error), 32'(model_error(DEPTH_A)));
      check({tag, "_err_b"}, 32'(bus_b.load_error), 32'(model_error(DEPTH_B)));
   endtask

   task automatic send(input logic [7:0] b, input bit last);
      bit acc;
      int waited;
      waited = 0;
      load_valid = 1'b1;
      load_byte = b;
      load_last = last;
      do begin
         acc = bus_a.load_ready && clk_enable;
         @(posedge clk);
         if (!acc) begin
            @(negedge clk);
            waited++;
         end
      end while (!acc && waited < 20);
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
      @(negedge clk);
      load_valid = 1'b0;
      load_last = 1'b0;
      m_bytes.push_back(b);
      if (last) model_finish();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b0;
      load_valid = 1'b0;
      load_last = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rst_ready_a"}, 32'(bus_a.load_ready), 32'd0);
      check({tag, "_rst_ready_b"}, 32'(bus_b.load_ready), 32'd0);
      check({tag, "_rst_done_a"}, 32'(bus_a.load_done), 32'd0);
      check({tag, "_rst_err_b"}, 32'(bus_b.load_error), 32'd0);
      fetch({tag, "_rst_read"}, BASE);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_status({tag, "_post_rst"});
   endtask

   initial begin
      reset = 1'b0;
      clk_enable = 1'b1;
      load_valid = 1'b0;
      load_byte = 8'h00;
      load_last = 1'b0;
      instr_address = BASE;

      // Four-word program; deep instance keeps all, 2-word one overflows.
      do_reset("t1");
      for (int i = 0; i < 15; i++) begin
         send(prog1[i], 1'b0);
         if (i == 4) fetch("t1_pre_done", BASE);
      end
      send(prog1[15], 1'b1);
      fetch("t1_last_word", BASE + 32'hC);
      check_status("t1_done");
      for (int i = 0; i < 5; i++) fetch("t1_word", BASE + 32'(4 * i));
      fetch("t1_misaligned", BASE + 32'h2);
      fetch("t1_zero", 32'h0);
      fetch("t1_below", 32'hBFBFFFFC);

      do_reset("t2");
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      check_status("t2_done");
      fetch("t2_partial", BASE);
      fetch("t2_after", BASE + 32'h4);

      do_reset("t3");
      for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), i == 11);
      check_status("t3_done");
      for (int i = 0; i < 3; i++) fetch("t3_word", BASE + 32'(4 * i));

      do_reset("t4");
      for (int i = 0; i < 6; i++) send(8'hE0 + 8'(i), 1'b0);
      do_reset("t4b");
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      fetch("t4_word0", BASE);
      fetch("t4_word1", BASE + 32'h4);

      do_reset("t5");
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      clk_enable = 1'b0;
      fork
         send(8'h03, 1'b0);
         begin
            for (int i = 0; i < 3; i++) begin
               @(posedge clk);
               #1;
               check("t5_stall_ready", 32'(bus_a.load_ready), 32'd1);
            end
            clk_enable = 1'b1;
         end
      join
      send(8'h04, 1'b1);
      check_status("t5_done");
      fetch("t5_word0", BASE);
      fetch("t5_word1", BASE + 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
